counter_seq_ctrl: RTL

- Moore-style sequencer for the modulo counter datapath: clears it, enables it for a programmed number of full count cycles ("runs") and inserts a programmable idle delay between runs.
- Reports completion with a one-cycle `done` pulse.
- Sits between the control/test logic and the enable/clear-capable variant of the mod-N counter, and observes the counter's `q` as feedback.

---
 rtl/counter_seq_ctrl_if.sv | 28 ++
 rtl/counter_seq_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl_if.sv
// rtl/counter_seq_ctrl_if.sv - control and counter-feedback bundle for counter_seq_ctrl
interface counter_seq_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int RUN_W = 8,
  parameter int DLY_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] modulus;
  logic [RUN_W-1:0] runs;
  logic [DLY_W-1:0] delay;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_en;
  logic             cnt_clr;
  logic             busy;
  logic             done;
  logic [RUN_W-1:0] run_idx;

  modport master (
    output start, abort, modulus, runs, delay, cnt_q,
    input  cnt_en, cnt_clr, busy, done, run_idx
  );

  modport slave (
    input  start, abort, modulus, runs, delay, cnt_q,
    output cnt_en, cnt_clr, busy, done, run_idx
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - clear/run/delay sequencer driving a mod-N counter
// CNT_SEQ_CONTINUOUS_EN: runs==0 at start counts forever until abort.
module counter_seq_ctrl #(
  parameter int CNT_W = 4,
  parameter int RUN_W = 8,
  parameter int DLY_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  counter_seq_ctrl_if.slave bus
);
`ifdef CNT_SEQ_CONTINUOUS_EN
  localparam bit ZERO_RUNS_CONT = 1'b1;
`else
  localparam bit ZERO_RUNS_CONT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COUNT, S_DELAY, S_ABORT, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_mod;
  logic [RUN_W-1:0] r_runs;
  logic [RUN_W-1:0] r_run_idx;
  logic [RUN_W-1:0] w_run_inc;
  logic [DLY_W-1:0] r_dly;
  logic [DLY_W-1:0] r_dly_cnt;
  logic             r_cont;
  logic             r_cnt_en;
  logic             r_cnt_clr;
  logic             r_busy;
  logic             r_done;
  logic             w_wrap;
  logic             w_last_run;
  logic             w_zero_runs;

  assign w_wrap      = (bus.cnt_q == r_mod);
  assign w_run_inc   = r_run_idx + 1'b1;
  assign w_last_run  = !r_cont && (w_run_inc == r_runs);
  assign w_zero_runs = (bus.runs == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = (w_zero_runs && !ZERO_RUNS_CONT) ? S_DONE : S_CLEAR;
      S_CLEAR: w_next = bus.abort ? S_ABORT : S_COUNT;
      S_COUNT: begin
        // abort wins over a wrap in the same cycle
        if (bus.abort)       w_next = S_ABORT;
        else if (w_wrap) begin
          if (w_last_run)          w_next = S_DONE;
          else if (r_dly == '0)    w_next = S_COUNT;
          else                     w_next = S_DELAY;
        end
      end
      S_DELAY: begin
        if (bus.abort)             w_next = S_ABORT;
        else if (r_dly_cnt == '0)  w_next = S_COUNT;
      end
      S_ABORT: w_next = S_IDLE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_mod     <= '0;
      r_runs    <= '0;
      r_dly     <= '0;
      r_dly_cnt <= '0;
      r_cont    <= 1'b0;
      r_run_idx <= '0;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt_en  <= (w_next == S_COUNT);
      r_cnt_clr <= (w_next == S_CLEAR) || (w_next == S_ABORT);
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);

      if (r_state == S_IDLE && bus.start) begin
        r_mod     <= bus.modulus;
        r_runs    <= bus.runs;
        r_dly     <= bus.delay;
        r_cont    <= ZERO_RUNS_CONT && w_zero_runs;
        r_run_idx <= '0;
      end else if (r_state == S_COUNT && !bus.abort && w_wrap &&
                   (r_cont || r_run_idx != r_runs)) begin
        r_run_idx <= w_run_inc;
      end

      // delay counter is loaded with delay-1 so DELAY lasts exactly delay cycles
      if (r_state == S_COUNT && w_next == S_DELAY)
        r_dly_cnt <= r_dly - 1'b1;
      else if (r_state == S_DELAY && r_dly_cnt != '0)
        r_dly_cnt <= r_dly_cnt - 1'b1;
    end
  end

  assign bus.cnt_en  = r_cnt_en;
  assign bus.cnt_clr = r_cnt_clr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.run_idx = r_run_idx;
endmodule
